// File: rtl/fft_sdf_sequencer.sv
// fft_sdf_sequencer
//
// Central timing controller for a radix-2 single-path delay-feedback FFT.
// A single valid-bit shift register models the whole pipeline: every
// per-stage feedback delay and every inter-stage register. Each stage's
// input and output valid bits are fixed taps on that register. Counters on
// those taps derive the per-stage butterfly phase, the twiddle enable and
// the twiddle exponent. An output counter produces the bit-reversed bin
// index and the frame-done pulse.
//
// Ports:
//   clk            clock, all state on the rising edge
//   rst_n          asynchronous active-low reset
//   in_valid       one input sample per cycle while high
//   stage_bf       bit k: stage k is in its butterfly (add/sub) phase
//   stage_tw_en    bit k: stage k output must be multiplied by its twiddle
//   stage_tw_addr  field k (LOG2N-1 bits): twiddle exponent for stage k
//   out_valid      FFT output sample valid
//   out_idx        frequency bin of the current output (bit-reversed order)
//   frame_done     one-cycle pulse on the last output sample of a frame
//   busy           any sample is still in flight
//   in_err         sticky flag: in_valid dropped in the middle of a frame

module fft_sdf_sequencer #(
    parameter int LOG2N = 7,
    parameter int PIPE  = 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    output logic [LOG2N-1:0]               stage_bf,
    output logic [LOG2N-1:0]               stage_tw_en,
    output logic [LOG2N*(LOG2N-1)-1:0]     stage_tw_addr,
    output logic                           out_valid,
    output logic [LOG2N-1:0]               out_idx,
    output logic                           frame_done,
    output logic                           busy,
    output logic                           in_err
);

    localparam int N   = 1 << LOG2N;
    localparam int TAW = LOG2N - 1;
    // Total delay from in_valid to out_valid: sum of 2^(LOG2N-1-k) over all
    // stages, plus PIPE registers after each stage.
    localparam int TOT = N - 1 + LOG2N * PIPE;

    // Twiddle exponent for stage k: (m mod D_k) scaled by 2^k so that each
    // stage indexes the same N-point twiddle ROM.
    function automatic logic [TAW-1:0] tw_exp(input logic [LOG2N-1:0] m, input int k);
        logic [LOG2N-1:0] mask;
        mask = (LOG2N'(1) << (LOG2N - 1 - k)) - LOG2N'(1);
        return TAW'((m & mask) << k);
    endfunction

    // Gating with rst_n makes every output drop to 0 as soon as reset
    // asserts, even if the source keeps in_valid high.
    logic iv0;
    assign iv0 = in_valid & rst_n;

    logic [TOT-1:0]   sr_q, sr_d;
    logic [LOG2N-1:0] q_q, q_d;
    logic             in_err_q, in_err_d;
    logic             n0_nz;
    logic [LOG2N-1:0] q_rev;

    always_comb begin
        sr_d     = {sr_q[TOT-2:0], iv0};
        q_d      = q_q + {{TAW{1'b0}}, out_valid};
        in_err_d = in_err_q | (~iv0 & n0_nz);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q     <= '0;
            q_q      <= '0;
            in_err_q <= 1'b0;
        end else begin
            sr_q     <= sr_d;
            q_q      <= q_d;
            in_err_q <= in_err_d;
        end
    end

    genvar k;
    generate
        for (k = 0; k < LOG2N; k++) begin : g_stage
            // ov_k sits at cumulative delay 2^LOG2N - D_k + k*PIPE.
            localparam int OV_TAP = N - (1 << (LOG2N - 1 - k)) + k * PIPE - 1;

            logic             iv_k, ov_k;
            logic [LOG2N-1:0] n_q, n_d, m_q, m_d;

            if (k == 0) begin : g_first
                assign iv_k  = iv0;
                assign n0_nz = |n_q;
            end else begin : g_rest
                // iv_k sits at ov_(k-1)'s delay plus PIPE.
                localparam int IV_TAP = N - (1 << (LOG2N - k)) + k * PIPE - 1;
                assign iv_k = sr_q[IV_TAP];
            end
            assign ov_k = sr_q[OV_TAP];

            always_comb begin
                n_d = n_q + {{TAW{1'b0}}, iv_k};
                m_d = m_q + {{TAW{1'b0}}, ov_k};
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    n_q <= '0;
                    m_q <= '0;
                end else begin
                    n_q <= n_d;
                    m_q <= m_d;
                end
            end

            // The second half of each 2*D_k block is the butterfly phase on
            // the input side and the difference-term phase on the output side.
            assign stage_bf[k]                = iv_k & n_q[LOG2N-1-k];
            assign stage_tw_en[k]             = ov_k & m_q[LOG2N-1-k];
            assign stage_tw_addr[k*TAW +: TAW] = stage_tw_en[k] ? tw_exp(m_q, k) : '0;
        end

        for (k = 0; k < LOG2N; k++) begin : g_rev
            assign q_rev[k] = q_q[LOG2N-1-k];
        end
    endgenerate

    assign out_valid  = sr_q[TOT-1];
    assign out_idx    = out_valid ? q_rev : '0;
    assign frame_done = out_valid & (&q_q);
    assign busy       = iv0 | (|sr_q);
    assign in_err     = in_err_q;

endmodule

// File: tb/tb_fft_sdf_sequencer.sv
// Directed testbench for fft_sdf_sequencer.
// Instance a: defaults (LOG2N=7, PIPE=1). Instance b: LOG2N=5, PIPE=0.
// Cycle c is the interval following a rising edge. Inputs are driven 1 ns
// after the edge, and outputs are sampled on the falling edge.

module tb_fft_sdf_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic in_valid;
    logic in_valid_b;

    logic [6:0]  a_bf, a_twen, a_idx;
    logic [41:0] a_addr;
    logic        a_ov, a_done, a_busy, a_err;

    logic [4:0]  b_bf, b_twen, b_idx;
    logic [19:0] b_addr;
    logic        b_ov, b_done, b_busy, b_err;

    fft_sdf_sequencer dut_a (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .stage_bf      (a_bf),
        .stage_tw_en   (a_twen),
        .stage_tw_addr (a_addr),
        .out_valid     (a_ov),
        .out_idx       (a_idx),
        .frame_done    (a_done),
        .busy          (a_busy),
        .in_err        (a_err)
    );

    fft_sdf_sequencer #(.LOG2N(5), .PIPE(0)) dut_b (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid_b),
        .stage_bf      (b_bf),
        .stage_tw_en   (b_twen),
        .stage_tw_addr (b_addr),
        .out_valid     (b_ov),
        .out_idx       (b_idx),
        .frame_done    (b_done),
        .busy          (b_busy),
        .in_err        (b_err)
    );

    int tests_run    = 0;
    int tests_failed = 0;
    int c            = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, c, obs, exp);
        end
    endtask

    function automatic logic [6:0] brev7(input logic [6:0] x);
        logic [6:0] r;
        r = {<<{x}};
        return r;
    endfunction

    function automatic logic inr(input int x, input int lo, input int hi);
        return (x >= lo) && (x <= hi);
    endfunction

    task automatic tick(input logic iv, input logic ivb, input logic rn);
        @(posedge clk);
        #1;
        rst_n      = rn;
        in_valid   = iv;
        in_valid_b = ivb;
        @(negedge clk);
    endtask

    task automatic reset_dut();
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_valid_b = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_a_ctl",  {a_bf, a_twen, a_ov, a_idx, a_done, a_busy, a_err}, 64'd0);
        chk("rst_a_addr", a_addr, 64'd0);
        chk("rst_b_all",  {b_bf, b_twen, b_addr, b_ov, b_idx, b_done, b_busy, b_err}, 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        // Single frame: in_valid for cycles 0..127.
        reset_dut();
        for (c = 0; c < 300; c++) begin
            tick(c < 128, 1'b0, 1'b1);
            chk("t1_bf0",    a_bf[0],   inr(c, 64, 127));
            chk("t1_twen0",  a_twen[0], inr(c, 128, 191));
            chk("t1_addr0",  a_addr[5:0], inr(c, 128, 191) ? 64'(c - 128) : 64'd0);
            chk("t1_bf1",    a_bf[1],   inr(c, 97, 128) || inr(c, 161, 192));
            chk("t1_twen1",  a_twen[1], inr(c, 129, 160) || inr(c, 193, 224));
            chk("t1_addr1",  a_addr[11:6],
                inr(c, 129, 160) ? 64'(2 * (c - 129)) :
                inr(c, 193, 224) ? 64'(2 * (c - 193)) : 64'd0);
            chk("t1_addr6",  a_addr[41:36], 64'd0);
            chk("t1_ovld",   a_ov,  inr(c, 134, 261));
            chk("t1_idx",    a_idx, inr(c, 134, 261) ? 64'(brev7(7'(c - 134))) : 64'd0);
            chk("t1_done",   a_done, c == 261);
            chk("t1_busy",   a_busy, c <= 261);
            chk("t1_err",    a_err, 64'd0);
        end

        // Back-to-back frames: in_valid for cycles 0..255.
        reset_dut();
        for (c = 0; c < 400; c++) begin
            tick(c < 256, 1'b0, 1'b1);
            chk("t2_ovld", a_ov, inr(c, 134, 389));
            chk("t2_done", a_done, (c == 261) || (c == 389));
            chk("t2_busy", a_busy, c <= 389);
            chk("t2_err",  a_err, 64'd0);
            if (c == 261) chk("t2_idx261", a_idx, 64'd127);
            if (c == 262) chk("t2_idx262", a_idx, 64'd0);
            if (c == 263) chk("t2_idx263", a_idx, 64'd64);
            if (c == 389) chk("t2_idx389", a_idx, 64'd127);
        end

        // Gap at cycle 50; the error flag must stick across later traffic.
        reset_dut();
        for (c = 0; c < 450; c++) begin
            tick((c < 384) && (c != 50), 1'b0, 1'b1);
            chk("t3_err", a_err, c >= 51);
        end

        // Reset mid-frame at cycle 100, new frame at 200..327.
        reset_dut();
        chk("t4_err_cleared", a_err, 64'd0);
        for (c = 0; c < 341; c++) begin
            tick((c <= 100) || inr(c, 200, 327), 1'b0, !inr(c, 100, 105));
            if (c == 99) begin
                chk("t4_bf0_pre",  a_bf[0], 64'd1);
                chk("t4_busy_pre", a_busy, 64'd1);
            end
            if (inr(c, 100, 105)) begin
                chk("t4_rst_ctl",  {a_bf, a_twen, a_ov, a_idx, a_done, a_busy, a_err}, 64'd0);
                chk("t4_rst_addr", a_addr, 64'd0);
            end
            if (inr(c, 106, 199)) chk("t4_busy_idle", a_busy, 64'd0);
            if (c == 200) chk("t4_busy_restart", a_busy, 64'd1);
            chk("t4_ovld", a_ov, c >= 334);
            if (c == 334) chk("t4_idx_first", a_idx, 64'd0);
        end

        // LOG2N=5, PIPE=0: 32-sample frame.
        reset_dut();
        for (c = 0; c < 70; c++) begin
            tick(1'b0, c < 32, 1'b1);
            chk("t5_ovld",  b_ov,    inr(c, 31, 62));
            chk("t5_twen0", b_twen[0], inr(c, 32, 47));
            chk("t5_addr0", b_addr[3:0], inr(c, 32, 47) ? 64'(c - 32) : 64'd0);
            chk("t5_bf0",   b_bf[0], inr(c, 16, 31));
            chk("t5_done",  b_done,  c == 62);
            chk("t5_err",   b_err,   64'd0);
            chk("t5_a_idle", a_busy, 64'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/fft_sdf_sequencer.md
# fft_sdf_sequencer

Central timing controller for the 128-point radix-2 single-path delay-feedback (SDF) FFT pipeline. It tracks the sample stream as it moves through all LOG2N stages. For each stage it drives the butterfly-mode select, the twiddle-multiply enable and the twiddle address used by that stage's twiddle ROM. It also produces the pipeline's output valid, the bit-reversed output index and frame-completion pulses, so individual stages no longer need their own free-running counters.

## Interface
- LOG2N, 7: log2 of FFT size. Stage k (0..LOG2N-1) has feedback delay D_k = 2^(LOG2N-1-k).
- PIPE, 1: register stages between successive FFT stages. Range 0..3.
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  one input sample per cycle when high; frames are 2^LOG2N contiguous samples
- stage_bf  out  LOG2N  bit k high: stage k in butterfly phase (add/sub); low: fill phase (store/pass)
- stage_tw_en  out  LOG2N  bit k high: stage k output is a difference term and must be multiplied by its twiddle
- stage_tw_addr  out  LOG2N*(LOG2N-1)  field k, bits [k*(LOG2N-1) +: LOG2N-1], holds exponent e of W_{2^LOG2N}^e
- out_valid  out  1  FFT output sample valid
- out_idx  out  LOG2N  frequency bin of the current output (bit-reversed output order)
- frame_done  out  1  one-cycle pulse on the last output sample of a frame
- busy  out  1  any stage holds live samples
- in_err  out  1  sticky: in_valid dropped mid-frame

## Operation
- Valid chain:
  - iv_0 = in_valid.
  - ov_k = iv_k delayed D_k cycles.
  - iv_{k+1} = ov_k delayed PIPE cycles.
  - out_valid = iv_LOG2N.
  - Implement with shift registers or per-stage countdowns. Either way, behaviour must equal the delayed-bit model exactly.
- Per stage, input counter n_k (LOG2N bits) increments on iv_k and wraps mod 2^LOG2N.
- Per stage, output counter m_k (LOG2N bits) increments on ov_k and wraps mod 2^LOG2N.
- stage_bf[k] = iv_k & n_k[LOG2N-1-k]. This is the second half of each 2*D_k input block.
- stage_tw_en[k] = ov_k & m_k[LOG2N-1-k].
- stage_tw_addr field k = (m_k mod D_k) << k while stage_tw_en[k] is high; otherwise 0.
  - Stage 0 spans e = 0..63. Stage 1 steps by 2. Stage LOG2N-1 is always 0.
- Output counter q increments on out_valid and wraps.
  - out_idx = bit-reverse(q) while out_valid; otherwise 0.
  - frame_done = out_valid & (q == 2^LOG2N - 1).
- busy = OR of all iv_k and ov_k bits, including the PIPE delay registers.
- Back-to-back frames need no gap; counters simply wrap. Idle between frames is allowed.
- in_err is set when in_valid falls while n_0 != 0. It stays set until reset.
  - After a protocol error, sequencing continues on the valid chain as-is: gaps propagate, and counters count only valid slots.
- Stages run freely with no stall input and no backpressure.

## Timing
- Reset: every output and internal counter/delay bit is 0. A mid-frame reset discards all in-flight samples immediately.
- The first in_valid after reset is treated as sample 0 of a frame.
- Outputs are registered functions of the delay chain, aligned to the cycle in which the stage sees the sample or emits the output. There is no extra lag.
- Latency from the first in_valid cycle t0 to the first out_valid is (2^LOG2N - 1) + LOG2N*PIPE. This is 134 at the defaults.
- A frame's out_valid lasts 2^LOG2N consecutive cycles when input was contiguous.
- busy falls the cycle after the last out_valid.
- A simultaneous last output of frame j and first output of frame j+1 cannot occur. Output slots are one per cycle, and q wraps 127 -> 0 seamlessly.

## Test plan
- Single frame (defaults), in_valid high for cycles 0..127:
  - stage_bf[0] high for cycles 64..127.
  - stage_tw_en[0] high for cycles 128..191 with address 0,1,..,63.
  - stage_bf[1] high for cycles 97..128 and 161..192.
  - stage_tw_en[1] high for cycles 129..160 and 193..224 with address 0,2,..,62.
- Same frame, output side:
  - out_valid high for cycles 134..261.
  - out_idx sequence 0,64,32,96,16,...,127.
  - frame_done high only at cycle 261.
  - busy low from cycle 262.
- Back-to-back frames, in_valid high for cycles 0..255:
  - out_valid continuous for cycles 134..389.
  - frame_done at 261 and 389.
  - out_idx returns to 0 at cycle 262.
  - in_err stays 0.
- Gap: in_valid low at cycle 50 of a frame -> in_err = 1 from cycle 51 and stays 1 through subsequent frames until rst_n is low.
- Reset mid-frame: rst_n low at cycle 100 -> all outputs 0 at once. A new frame started at cycle 200 after release gives first out_valid at cycle 334.
- PIPE=0, LOG2N=5:
  - 32-sample frame gives first out_valid 31 cycles after t0.
  - stage_tw_en[0] high for cycles 32..47 with address 0..15.
